// File: rtl/fm_pkg.sv
// fm_pkg: shared defaults and enums for the C/Occ table server.
package fm_pkg;
  localparam int SYM_W  = 2;
  localparam int C_W    = 8;
  localparam int OCC_AW = 8;
  localparam int OCC_DW = 32;
  typedef enum logic [1:0] {IDLE, ISSUED, RESP} lane_state_e;
  typedef enum logic {REQ_C, REQ_OCC} req_kind_e;
endpackage

// File: rtl/fm_table_server_if.sv
// fm_table_server_if: per-lane request/response bundle between lanes and the table server.
interface fm_table_server_if #(
  parameter int NUM_LANES = 4,
  parameter int OCC_AW    = 8,
  parameter int OCC_DW    = 32
);
  logic [NUM_LANES-1:0]        req_valid;
  logic [NUM_LANES-1:0]        req_ready;
  logic [NUM_LANES-1:0]        req_is_occ;
  logic [NUM_LANES*OCC_AW-1:0] req_addr;
  logic [NUM_LANES-1:0]        rsp_valid;
  logic [NUM_LANES-1:0]        rsp_ready;
  logic [NUM_LANES*OCC_DW-1:0] rsp_data;
  modport master (output req_valid, req_is_occ, req_addr, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data);
  modport slave  (input  req_valid, req_is_occ, req_addr, rsp_ready,
                  output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fm_rr_arbiter.sv
// fm_rr_arbiter: round-robin pick starting at ptr; reports the one-hot winner and the pointer past it.
module fm_rr_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int PW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1
) (
  input  logic [PW-1:0]        ptr,
  input  logic [NUM_LANES-1:0] req,
  output logic [NUM_LANES-1:0] grant,
  output logic [PW-1:0]        nxt,
  output logic                 any
);
  logic [PW-1:0] idx;
  always_comb begin
    grant = '0;
    nxt   = ptr;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_LANES);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        nxt        = PW'((int'(idx) + 1) % NUM_LANES);
      end
    end
  end
endmodule

// File: rtl/fm_table_server.sv
// fm_table_server: round-robin shared C/Occ ROM lookup server for NUM_LANES lanes.
// OCC_DUAL_PORT_EN adds a second Occ grant per cycle on the rom_Occ port 2.
module fm_table_server #(
  parameter int NUM_LANES = 4,
  parameter int SYM_W     = fm_pkg::SYM_W,
  parameter int C_W       = fm_pkg::C_W,
  parameter int OCC_AW    = fm_pkg::OCC_AW,
  parameter int OCC_DW    = fm_pkg::OCC_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  fm_table_server_if.slave  lanes,
  output logic              ce_rom_C_o,
  output logic [SYM_W-1:0]  addr_rom_C_o,
  input  logic [C_W-1:0]    data_C_i,
  output logic              ce_rom_Occ_o,
  output logic [OCC_AW-1:0] addr1_rom_Occ_o,
  input  logic [OCC_DW-1:0] data_1_i,
  output logic [OCC_AW-1:0] addr2_rom_Occ_o,
  input  logic [OCC_DW-1:0] data_2_i
);
  import fm_pkg::*;
  localparam int PW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  logic [NUM_LANES-1:0] req_c, req_o, g_c, g_o1, g_o2, idle;
  logic [PW-1:0]        ptr_c, ptr_o, nxt_c, nxt_o1, nxt_o2;
  logic                 any_c, any_o1, any_o2;
  logic [SYM_W-1:0]     a_c;
  logic [OCC_AW-1:0]    a_o1, a_o2;
  assign req_c = lanes.req_valid & ~lanes.req_is_occ & idle;
  assign req_o = lanes.req_valid & lanes.req_is_occ & idle;
  assign lanes.req_ready = (g_c | g_o1 | g_o2) & {NUM_LANES{rst_n}};
  fm_rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb_c (
    .ptr(ptr_c), .req(req_c), .grant(g_c), .nxt(nxt_c), .any(any_c));
  fm_rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb_o1 (
    .ptr(ptr_o), .req(req_o), .grant(g_o1), .nxt(nxt_o1), .any(any_o1));
`ifdef OCC_DUAL_PORT_EN
  // Same pointer with the first winner masked: yields the next requester after it in RR order.
  fm_rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb_o2 (
    .ptr(ptr_o), .req(req_o & ~g_o1), .grant(g_o2), .nxt(nxt_o2), .any(any_o2));
`else
  assign g_o2   = '0;
  assign nxt_o2 = ptr_o;
  assign any_o2 = 1'b0;
`endif
  always_comb begin
    a_c  = '0;
    a_o1 = '0;
    a_o2 = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      a_c  = g_c[i]  ? lanes.req_addr[i*OCC_AW +: SYM_W]  : a_c;
      a_o1 = g_o1[i] ? lanes.req_addr[i*OCC_AW +: OCC_AW] : a_o1;
      a_o2 = g_o2[i] ? lanes.req_addr[i*OCC_AW +: OCC_AW] : a_o2;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_rom_C_o      <= 1'b0;
      addr_rom_C_o    <= '0;
      ce_rom_Occ_o    <= 1'b0;
      addr1_rom_Occ_o <= '0;
      addr2_rom_Occ_o <= '0;
      ptr_c           <= '0;
      ptr_o           <= '0;
    end else begin
      ce_rom_C_o   <= any_c;
      ce_rom_Occ_o <= any_o1;
      if (any_c) begin
        addr_rom_C_o <= a_c;
        ptr_c        <= nxt_c;
      end
      if (any_o1) begin
        addr1_rom_Occ_o <= a_o1;
        ptr_o           <= any_o2 ? nxt_o2 : nxt_o1;
      end
      if (any_o2) addr2_rom_Occ_o <= a_o2;
    end
  end
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_state_e       st, st_n;
    req_kind_e         kind;
    logic              p2;
    logic [OCC_DW-1:0] data_q;
    logic              gnt;
    assign gnt   = g_c[i] | g_o1[i] | g_o2[i];
    assign idle[i] = st == IDLE;
    assign lanes.rsp_valid[i] = st == RESP;
    assign lanes.rsp_data[i*OCC_DW +: OCC_DW] = data_q;
    always_comb begin
      st_n = st == IDLE   ? (gnt ? ISSUED : IDLE) :
             st == ISSUED ? RESP :
             (lanes.rsp_ready[i] ? IDLE : RESP);
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= IDLE;
        kind   <= REQ_C;
        p2     <= 1'b0;
        data_q <= '0;
      end else begin
        st <= st_n;
        if (st == IDLE) begin
          kind <= (g_o1[i] | g_o2[i]) ? REQ_OCC : REQ_C;
          p2   <= g_o2[i];
        end
        if (st == ISSUED)
          data_q <= kind == REQ_OCC ? (p2 ? data_2_i : data_1_i) : OCC_DW'(data_C_i);
      end
    end
  end
endmodule
